// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time loader that receives a program over a byte stream and writes it
// into instruction memory, holding the processor core in reset until the
// whole program has landed.
//
// Session format: one length byte N (1..MAX_WORDS), then 2N bytes forming
// N 16-bit instruction words, high byte first. Each completed word is
// written in a single WRITE cycle to byte address 2*word_index. After the
// last word, the core is released from reset. A start pulse in RUN begins
// a reload. A bad length byte sets a sticky error flag and returns to IDLE.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       begin a load session (honoured in IDLE and RUN only)
//   in_valid    byte stream valid
//   in_data     byte stream data
//   in_ready    loader accepts in_data this cycle
//   imem_we     instruction-memory write strobe (WRITE state only)
//   imem_addr   byte address of the write, always even
//   imem_wdata  instruction word to write
//   cpu_rst     hold-reset to the core, active-high
//   load_done   program loaded and core running
//   err_len     sticky flag: last length byte was 0 or above MAX_WORDS
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int MAX_WORDS     = 16,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [15:0]              imem_wdata,
    output logic                     cpu_rst,
    output logic                     load_done,
    output logic                     err_len
);

    // Wide enough to hold N itself (up to MAX_WORDS), not just an index.
    localparam int          CW      = $clog2(MAX_WORDS + 1);
    localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        WRITE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] n_words;
    logic [CW-1:0] word_index;
    logic [7:0]    hi_byte;
    logic          len_ok;
    logic          last_word;

    assign len_ok    = (in_data != 8'd0) && ({24'd0, in_data} <= MAX_LEN);
    assign last_word = (word_index == n_words - CW'(1));

    // Next state and state-decoded outputs. in_valid is used directly in the
    // accepting states (where in_ready is 1) so this block never reads its
    // own in_ready output back.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a variable unassigned, which would infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        cpu_rst    = 1'b1;
        load_done  = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_next = LEN;
            end
            LEN: begin
                in_ready = 1'b1;
                if (in_valid) state_next = len_ok ? HI : IDLE;
            end
            HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LO;
            end
            LO: begin
                in_ready = 1'b1;
                if (in_valid) state_next = WRITE;
            end
            WRITE: begin
                imem_we    = 1'b1;
                state_next = last_word ? RUN : HI;
            end
            RUN: begin
                cpu_rst   = 1'b0;
                load_done = 1'b1;
                if (start) state_next = LEN;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and datapath. rst wins over start and the handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            n_words    <= '0;
            word_index <= '0;
            hi_byte    <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err_len    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) err_len <= 1'b0;
                end
                LEN: begin
                    if (in_valid) begin
                        if (len_ok) begin
                            n_words    <= CW'(in_data);
                            word_index <= '0;
                        end else begin
                            err_len <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (in_valid) hi_byte <= in_data;
                end
                LO: begin
                    // Address and data are loaded on the edge into WRITE and
                    // then simply held, so they stay stable outside WRITE.
                    if (in_valid) begin
                        imem_addr  <= ADDRESS_WIDTH'({word_index, 1'b0});
                        imem_wdata <= {hi_byte, in_data};
                    end
                end
                WRITE: begin
                    if (!last_word) word_index <= word_index + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. The reference is a list of the
// memory writes a session must produce, derived from the length byte and the
// payload bytes; the bench monitors every imem_we cycle and compares the
// observed write list against it, plus timing and flag checks.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int MAX_WORDS = 16;
    localparam int AW        = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_rst;
    logic          load_done;
    logic          err_len;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  payload[$];
    logic [23:0] obs_q[$];

    program_loader #(
        .MAX_WORDS     (MAX_WORDS),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every write seen by memory.
    always @(negedge clk) begin
        if (imem_we === 1'b1) obs_q.push_back({imem_addr, imem_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic int pick_gap(input int gap_mode);
        return (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
    endfunction

    // Present one byte after 'gap' idle cycles carrying garbage data, and
    // return right after the edge that transferred it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("handshake_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Run one session from LEN. 'start_hi_word' >= 1 pulses start while the
    // FSM waits in HI for that word; it must be ignored.
    task automatic run_load(input logic [7:0] len, input int gap_mode,
                            input int start_hi_word, input string tag);
        logic [23:0] exp_q[$];
        bit          ok;
        ok = (len >= 8'd1) && (int'(len) <= MAX_WORDS);
        obs_q.delete();
        check({tag, "_len_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_len_cpu_rst"}, 32'(cpu_rst), 32'd1);
        send_byte(len, pick_gap(gap_mode));
        if (!ok) begin
            check({tag, "_err_len"}, 32'(err_len), 32'd1);
            check({tag, "_err_idle_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_err_cpu_rst"}, 32'(cpu_rst), 32'd1);
            check({tag, "_err_done"}, 32'(load_done), 32'd0);
            tick();
            check({tag, "_err_no_write"}, 32'(obs_q.size()), 32'd0);
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({8'(2 * i), payload[2*i], payload[2*i+1]});
            if (i == start_hi_word) begin
                tick();
                pulse_start();
                check({tag, "_start_in_hi_ready"}, 32'(in_ready), 32'd1);
                check({tag, "_start_in_hi_we"}, 32'(imem_we), 32'd0);
            end
            send_byte(payload[2*i], pick_gap(gap_mode));
            send_byte(payload[2*i+1], pick_gap(gap_mode));
            // The write follows the LO byte in the very next cycle.
            check({tag, "_write_now"}, 32'(imem_we), 32'd1);
            check({tag, "_write_cpu_rst"}, 32'(cpu_rst), 32'd1);
        end
        tick();
        check({tag, "_run_cpu_rst"}, 32'(cpu_rst), 32'd0);
        check({tag, "_run_done"}, 32'(load_done), 32'd1);
        check({tag, "_run_we"}, 32'(imem_we), 32'd0);
        check({tag, "_write_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    task automatic fill_payload(input int words);
        payload.delete();
        for (int i = 0; i < 2 * words; i++) payload.push_back(8'($urandom));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({tag, "_load_done"}, 32'(load_done), 32'd0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_err_len"}, 32'(err_len), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] len;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();
        check("idle_cpu_rst", 32'(cpu_rst), 32'd1);

        // Two-word program with in_valid held high.
        payload = '{8'h12, 8'h34, 8'hA5, 8'h6B};
        pulse_start();
        run_load(8'd2, 0, -1, "basic");

        // Illegal lengths: zero, then MAX_WORDS+1.
        pulse_start();
        run_load(8'h00, 0, -1, "len_zero");
        pulse_start();
        check("start_clears_err", 32'(err_len), 32'd0);
        run_load(8'h11, 0, -1, "len_17");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_clears_err", 32'(err_len), 32'd0);

        // Full-depth program with in_valid toggling.
        fill_payload(16);
        pulse_start();
        run_load(8'd16, 1, -1, "full_toggle");

        // Reload from RUN.
        pulse_start();
        check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reload_done", 32'(load_done), 32'd0);
        payload = '{8'hFF, 8'hFF};
        run_load(8'd1, 0, -1, "reload");

        // start while waiting in HI is ignored.
        fill_payload(3);
        pulse_start();
        run_load(8'd3, 0, 1, "start_in_hi");

        // Reset mid-session in LO, with start and a valid byte competing.
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'hAB, 0);
        rst      = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hCD;
        tick();
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        check_reset_values("mid_reset");
        tick();
        check("mid_reset_stays_idle", 32'(in_ready), 32'd0);
        payload = '{8'h00, 8'hCD};
        pulse_start();
        run_load(8'd1, 0, -1, "after_reset");

        // Randomized sessions with random stalls and occasional bad lengths.
        for (int s = 0; s < 20; s++) begin
            if ($urandom_range(0, 3) == 0)
                len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_WORDS + 1, 255));
            else
                len = 8'($urandom_range(1, MAX_WORDS));
            fill_payload((int'(len) <= MAX_WORDS) ? int'(len) : 0);
            pulse_start();
            run_load(len, -1, -1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
